seg_scan_capture: RTL and testbench

Captures the multiplexed 7-segment output of a scanned multi-digit display and recovers the BCD digits being shown. It is the read-back counterpart of the BCD-to-7-segment display path. It sits between the display driver's segment/anode pins and a checker or host that consumes whole frames over a valid/ready handshake. It filters switching transients with a stability counter, decodes each digit's active-low segment pattern back to BCD, flags illegal patterns, and assembles one frame per full scan.

---
 rtl/seg_scan_capture.sv | 86 ++++++++
 tb/tb_seg_scan_capture.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers BCD frames from a scanned, active-low 7-segment display
module seg_scan_capture #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [DIGITS-1:0]   an,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   err_out,
    output logic                valid,
    input  logic                ready,
    output logic                overrun
);
    localparam int CW = $clog2(SETTLE) + 1;
    typedef enum logic {TRACK, HOLD} state_t;
    state_t              state;
    logic [DIGITS+6:0]   in_q;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] slots;
    logic [DIGITS-1:0]   errs, seen, hit;
    logic [3:0]          dig;
    logic                changed, smp, done;
    assign changed = {an, seg} != in_q;
    assign smp     = !changed && state == TRACK && cnt == CW'(SETTLE - 1);
    // blank or multi-low strobes select no slot, so such samples are dropped
    assign hit     = $onehot(~in_q[DIGITS+6:7]) ? ~in_q[DIGITS+6:7] : '0;
    assign done    = &seen;
    always_comb begin
        dig = 4'hF;
        case (in_q[6:0])
            7'b0000001: dig = 4'd0;
            7'b1001111: dig = 4'd1;
            7'b0010010: dig = 4'd2;
            7'b0000110: dig = 4'd3;
            7'b1001100: dig = 4'd4;
            7'b0100100: dig = 4'd5;
            7'b0100000: dig = 4'd6;
            7'b0001111: dig = 4'd7;
            7'b0000000: dig = 4'd8;
            7'b0000100: dig = 4'd9;
            default:    dig = 4'hF;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= '1;
            cnt     <= '0;
            state   <= TRACK;
            slots   <= '0;
            errs    <= '0;
            seen    <= '0;
            bcd_out <= '0;
            err_out <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (changed) begin
                in_q  <= {an, seg};
                cnt   <= '0;
                state <= TRACK;
            end else if (state == TRACK) begin
                if (smp) state <= HOLD;
                else cnt <= cnt + 1'b1;
            end
            if (smp)
                for (int i = 0; i < DIGITS; i++)
                    if (hit[i]) begin
                        slots[4*i +: 4] <= dig;
                        errs[i]         <= dig == 4'hF;
                    end
            seen <= (done ? '0 : seen) | (smp ? hit : '0);
            if (done && (!valid || ready)) begin
                bcd_out <= slots;
                err_out <= errs;
                valid   <= 1'b1;
            end else if (done) begin
                overrun <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed-vector bench for seg_scan_capture (DIGITS=4, SETTLE=2)
module tb_seg_scan_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        valid;
    logic        ready = 1'b1;
    logic        overrun;
    int          vectors = 0;
    int          miscompares = 0;
    localparam logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    seg_scan_capture #(.DIGITS(4), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an), .bcd_out(bcd_out),
        .err_out(err_out), .valid(valid), .ready(ready), .overrun(overrun)
    );
    always #5 clk = ~clk;
    function automatic logic [3:0] dn(input int d);
        logic [3:0] x;
        x = 4'b0001 << d;
        return ~x;
    endfunction
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic scan(input int d, input int v);
        drive(dn(d), PAT[v], 5);
    endtask
    task automatic test_reset;
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++; if (bcd_out !== 16'h0) begin miscompares++; $display("FAIL reset_bcd got %h want 0000", bcd_out); end
        vectors++; if (err_out !== 4'h0) begin miscompares++; $display("FAIL reset_err got %b want 0000", err_out); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask
    task automatic test_basic;
        ready = 1'b1;
        scan(0, 1); scan(1, 2); scan(2, 3);
        an = dn(3); seg = PAT[4];
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            vectors++; if (valid !== (j == 3)) begin miscompares++; $display("FAIL basic_valid edge %0d got %b want %b", j, valid, j == 3); end
            if (j == 3) begin
                vectors++; if (bcd_out !== 16'h4321) begin miscompares++; $display("FAIL basic_bcd got %h want 4321", bcd_out); end
                vectors++; if (err_out !== 4'h0) begin miscompares++; $display("FAIL basic_err got %b want 0000", err_out); end
            end
        end
    endtask
    task automatic test_illegal;
        ready = 1'b0;
        scan(0, 1); scan(1, 2); drive(dn(2), 7'b1111111, 5); scan(3, 4);
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL illegal_valid got %b want 1", valid); end
        vectors++; if (bcd_out !== 16'h4F21) begin miscompares++; $display("FAIL illegal_bcd got %h want 4f21", bcd_out); end
        vectors++; if (err_out !== 4'b0100) begin miscompares++; $display("FAIL illegal_err got %b want 0100", err_out); end
        ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL illegal_accept got %b want 0", valid); end
    endtask
    task automatic test_glitch;
        ready = 1'b0;
        scan(0, 1); drive(dn(1), PAT[8], 2); scan(1, 7); scan(2, 2);
        drive(dn(3), PAT[5], 2);
        drive(4'hF, 7'h7F, 10);
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL glitch_incomplete got %b want 0", valid); end
        scan(3, 3);
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL glitch_valid got %b want 1", valid); end
        vectors++; if (bcd_out !== 16'h3271) begin miscompares++; $display("FAIL glitch_bcd got %h want 3271", bcd_out); end
        vectors++; if (err_out !== 4'h0) begin miscompares++; $display("FAIL glitch_err got %b want 0000", err_out); end
        ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL glitch_accept got %b want 0", valid); end
    endtask
    task automatic test_overrun;
        ready = 1'b0;
        scan(0, 1); scan(1, 2); scan(2, 3); scan(3, 4);
        vectors++; if (bcd_out !== 16'h4321) begin miscompares++; $display("FAIL ovr_first_bcd got %h want 4321", bcd_out); end
        scan(0, 5); scan(1, 6); scan(2, 7);
        an = dn(3); seg = PAT[8];
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            vectors++; if (overrun !== (j == 3)) begin miscompares++; $display("FAIL ovr_pulse edge %0d got %b want %b", j, overrun, j == 3); end
            vectors++; if (valid !== 1'b1 || bcd_out !== 16'h4321) begin miscompares++; $display("FAIL ovr_hold edge %0d got %b/%h want 1/4321", j, valid, bcd_out); end
        end
        ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ovr_accept got %b want 0", valid); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_after got %b want 0", overrun); end
    endtask
    task automatic test_back_to_back;
        ready = 1'b0;
        scan(0, 9); scan(1, 0); scan(2, 1); scan(3, 2);
        vectors++; if (valid !== 1'b1 || bcd_out !== 16'h2109) begin miscompares++; $display("FAIL b2b_first got %b/%h want 1/2109", valid, bcd_out); end
        scan(0, 3); scan(1, 4); scan(2, 5);
        an = dn(3); seg = PAT[6];
        for (int j = 0; j < 5; j++) begin
            ready = j >= 3;
            @(posedge clk); #1;
            if (j == 2) begin
                vectors++; if (valid !== 1'b1 || bcd_out !== 16'h2109) begin miscompares++; $display("FAIL b2b_held got %b/%h want 1/2109", valid, bcd_out); end
            end
            if (j == 3) begin
                vectors++; if (valid !== 1'b1 || bcd_out !== 16'h6543) begin miscompares++; $display("FAIL b2b_new got %b/%h want 1/6543", valid, bcd_out); end
                vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun got %b want 0", overrun); end
            end
            if (j == 4) begin
                vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL b2b_accept got %b want 0", valid); end
            end
        end
    endtask
    task automatic test_blank;
        ready = 1'b0;
        scan(0, 1); scan(1, 2); scan(2, 3);
        drive(4'hF, PAT[8], 10);
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL blank_an got %b want 0", valid); end
        drive(4'b0011, PAT[8], 5);
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL multi_an got %b want 0", valid); end
        scan(3, 4);
        vectors++; if (valid !== 1'b1 || bcd_out !== 16'h4321) begin miscompares++; $display("FAIL blank_frame got %b/%h want 1/4321", valid, bcd_out); end
        ready = 1'b1;
        @(posedge clk); #1;
    endtask
    task automatic test_reset_mid;
        ready = 1'b0;
        scan(0, 5); scan(1, 5);
        test_reset;
        scan(2, 7); scan(3, 6);
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_partial got %b want 0", valid); end
        scan(0, 9); scan(1, 8);
        vectors++; if (valid !== 1'b1 || bcd_out !== 16'h6789) begin miscompares++; $display("FAIL rst_frame got %b/%h want 1/6789", valid, bcd_out); end
        vectors++; if (err_out !== 4'h0) begin miscompares++; $display("FAIL rst_err got %b want 0000", err_out); end
    endtask
    initial begin
        test_reset;
        test_basic;
        test_illegal;
        test_glitch;
        test_overrun;
        test_back_to_back;
        test_blank;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
